// File: rtl/req_arbiter8_pkg.sv
// Shared definitions for the eight-requester arbiter: sizes, FSM state
// encoding and small mask/decode helpers used by the top level.
package arb_pkg;

  localparam int N_REQ  = 8;
  localparam int ID_W   = 3;
  localparam int HOLD_W = 8;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // One-hot decode of a requester index.
  function automatic logic [N_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
    return {{(N_REQ-1){1'b0}}, 1'b1} << id;
  endfunction

  // All request bits whose index is strictly below 'id'.
  function automatic logic [N_REQ-1:0] below_mask(input logic [ID_W-1:0] id);
    return ({{(N_REQ-1){1'b0}}, 1'b1} << id) - {{(N_REQ-1){1'b0}}, 1'b1};
  endfunction

  // Saturating increment of the hold counter; it must never wrap.
  function automatic logic [HOLD_W-1:0] hold_inc(input logic [HOLD_W-1:0] cnt);
    return (cnt == {HOLD_W{1'b1}}) ? cnt : cnt + {{(HOLD_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/pri_enc8.sv
// Combinational 8-to-3 priority encoder, highest set index wins.
// With no bit set the index is 0 and 'any' is low.
module pri_enc8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] bits,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  // Scan upward so the last (highest) set bit overwrites lower ones.
  always_comb begin
    idx = {ID_W{1'b0}};
    any = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = bits[i] ? ID_W'(i) : idx;
      any = any | bits[i];
    end
  end

endmodule

// File: rtl/req_arbiter8.sv
// Eight-requester arbiter with round-robin or fixed priority. A grant is
// registered one cycle after a request is seen in IDLE and held until the
// owner signals done, withdraws its request, or the hold timeout fires.
// Every release passes through at least one IDLE cycle with no grant.
module req_arbiter8
  import arb_pkg::*;
#(
  parameter bit          RR_EN    = 1'b1,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic             preempt
);

  // Timeout compare value; unused (and kept at zero) when timeout is disabled.
  localparam bit              TO_EN     = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST = TO_EN ? HOLD_W'(MAX_HOLD - 1) : {HOLD_W{1'b0}};

  arb_state_e        state_r;
  logic [ID_W-1:0]   last_id_r;
  logic [HOLD_W-1:0] hold_cnt_r;

  logic [N_REQ-1:0]  mask_s;
  logic [N_REQ-1:0]  masked_s;
  logic [ID_W-1:0]   m_idx_s;
  logic              m_any_s;
  logic [ID_W-1:0]   r_idx_s;
  logic              r_any_s;
  logic [ID_W-1:0]   win_s;
  logic              owner_req_s;
  logic              timeout_s;
  logic              release_s;

  // Round-robin mask: only requesters below the previous winner; empty in fixed mode.
  always_comb begin
    mask_s = {N_REQ{1'b0}};
    if (RR_EN) begin
      mask_s = below_mask(last_id_r);
    end else begin
      mask_s = {N_REQ{1'b0}};
    end
  end

  assign masked_s = req & mask_s;

  pri_enc8 u_enc_masked (
    .bits (masked_s),
    .idx  (m_idx_s),
    .any  (m_any_s)
  );

  pri_enc8 u_enc_req (
    .bits (req),
    .idx  (r_idx_s),
    .any  (r_any_s)
  );

  // Winner select: masked candidates first, fall back to the full request set.
  always_comb begin
    win_s = r_idx_s;
    if (RR_EN && m_any_s) begin
      win_s = m_idx_s;
    end else begin
      win_s = r_idx_s;
    end
  end

  // Release causes evaluated while a grant is held.
  always_comb begin
    owner_req_s = req[gnt_id];
    timeout_s   = TO_EN && (hold_cnt_r == HOLD_LAST);
    release_s   = done || !owner_req_s || timeout_s;
  end

  // Arbiter FSM with registered grant outputs and round-robin history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ARB_IDLE;
      gnt        <= {N_REQ{1'b0}};
      gnt_id     <= {ID_W{1'b0}};
      gnt_valid  <= 1'b0;
      preempt    <= 1'b0;
      last_id_r  <= {ID_W{1'b0}};
      hold_cnt_r <= {HOLD_W{1'b0}};
    end else begin
      case (state_r)
        ARB_IDLE: begin
          preempt <= 1'b0;
          if (r_any_s) begin
            state_r    <= ARB_GRANT;
            gnt        <= id_to_onehot(win_s);
            gnt_id     <= win_s;
            gnt_valid  <= 1'b1;
            last_id_r  <= win_s;
            hold_cnt_r <= {HOLD_W{1'b0}};
          end else begin
            gnt       <= {N_REQ{1'b0}};
            gnt_valid <= 1'b0;
          end
        end
        ARB_GRANT: begin
          if (release_s) begin
            state_r   <= ARB_IDLE;
            gnt       <= {N_REQ{1'b0}};
            gnt_valid <= 1'b0;
            // Forced release is flagged only when nothing else asked for it.
            preempt   <= timeout_s && !done && owner_req_s;
          end else begin
            hold_cnt_r <= hold_inc(hold_cnt_r);
            preempt    <= 1'b0;
          end
        end
        default: begin
          state_r    <= ARB_IDLE;
          gnt        <= {N_REQ{1'b0}};
          gnt_valid  <= 1'b0;
          preempt    <= 1'b0;
          hold_cnt_r <= {HOLD_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_req_arbiter8.sv
// Bench for req_arbiter8: two instances (round-robin with MAX_HOLD=4, and
// fixed priority with no timeout) share the same stimulus and are compared
// every cycle against a cycle-level behavioural model of the arbiter rules.
module tb_req_arbiter8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;

  logic [7:0] gnt_rr, gnt_fp;
  logic [2:0] id_rr, id_fp;
  logic       val_rr, val_fp;
  logic       pre_rr, pre_fp;

  int checks;
  int errors;

  // model state, index 0 = round-robin instance, 1 = fixed-priority instance
  bit rr_p [2];
  int mh_p [2];
  bit m_valid [2];
  int m_owner [2];
  int m_last  [2];
  int m_cnt   [2];
  bit m_pre   [2];

  int rr_ids[$];

  req_arbiter8 #(.RR_EN(1'b1), .MAX_HOLD(4)) u_rr (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt_rr), .gnt_id(id_rr), .gnt_valid(val_rr), .preempt(pre_rr)
  );

  req_arbiter8 #(.RR_EN(1'b0), .MAX_HOLD(0)) u_fp (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt_fp), .gnt_id(id_fp), .gnt_valid(val_fp), .preempt(pre_fp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Winner per the arbitration rule: highest requester below last, else highest overall.
  function automatic int pick(input logic [7:0] r, input int last, input bit rr);
    int w;
    w = -1;
    if (rr) begin
      for (int i = 0; i < 8; i++) if (r[i] && i < last) w = i;
    end
    if (w < 0) begin
      for (int i = 0; i < 8; i++) if (r[i]) w = i;
    end
    return w;
  endfunction

  task automatic model_tick(input int k);
    bit by_done, by_wd, by_to;
    if (!rst_n) begin
      m_valid[k] = 1'b0; m_owner[k] = 0; m_last[k] = 0; m_cnt[k] = 0; m_pre[k] = 1'b0;
    end else if (!m_valid[k]) begin
      m_pre[k] = 1'b0;
      if (req != 8'h00) begin
        m_owner[k] = pick(req, m_last[k], rr_p[k]);
        m_last[k]  = m_owner[k];
        m_valid[k] = 1'b1;
        m_cnt[k]   = 0;
      end
    end else begin
      by_done = done;
      by_wd   = !req[m_owner[k]];
      by_to   = (mh_p[k] != 0) && (m_cnt[k] == mh_p[k] - 1);
      if (by_done || by_wd || by_to) begin
        m_valid[k] = 1'b0;
        m_pre[k]   = by_to && !by_done && !by_wd;
      end else begin
        m_pre[k] = 1'b0;
        if (m_cnt[k] < 255) m_cnt[k] = m_cnt[k] + 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input int k, input logic [7:0] g, input logic [2:0] id,
                           input logic v, input logic p);
    logic [7:0] eg;
    eg = m_valid[k] ? (8'h01 << m_owner[k]) : 8'h00;
    chk((k == 0) ? "rr_gnt" : "fp_gnt", g, eg);
    chk((k == 0) ? "rr_valid" : "fp_valid", {7'd0, v}, {7'd0, m_valid[k]});
    chk((k == 0) ? "rr_preempt" : "fp_preempt", {7'd0, p}, {7'd0, m_pre[k]});
    if (m_valid[k]) chk((k == 0) ? "rr_id" : "fp_id", {5'd0, id}, 8'(m_owner[k]));
  endtask

  // One clock: drive inputs, advance both models at the edge, compare after it.
  task automatic step(input logic [7:0] r, input logic d, input logic rn);
    req = r; done = d; rst_n = rn;
    @(posedge clk);
    model_tick(0);
    model_tick(1);
    #1;
    check_dut(0, gnt_rr, id_rr, val_rr, pre_rr);
    check_dut(1, gnt_fp, id_fp, val_fp, pre_fp);
  endtask

  initial begin
    logic [7:0] rq;
    checks = 0; errors = 0;
    rr_p[0] = 1'b1; mh_p[0] = 4;
    rr_p[1] = 1'b0; mh_p[1] = 0;
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = 1'b0; m_owner[k] = 0; m_last[k] = 0; m_cnt[k] = 0; m_pre[k] = 1'b0;
    end
    req = 8'h00; done = 1'b0; rst_n = 1'b0;
    @(negedge clk);

    // reset held with all requests up
    step(8'hFF, 1'b0, 1'b0);
    step(8'hFF, 1'b0, 1'b0);
    chk("reset_gnt", gnt_rr, 8'h00);

    // round-robin order with done held high: 7,2,0,7 in the rr instance
    for (int i = 0; i < 8; i++) begin
      step(8'h85, 1'b1, 1'b1);
      if (val_rr) rr_ids.push_back(int'(id_rr));
      if ((i % 2) == 0) chk("fp_fixed_gnt", gnt_fp, 8'h80);
      else chk("rr_gap", gnt_rr, 8'h00);
    end
    chk("rr_count", 8'(rr_ids.size()), 8'd4);
    if (rr_ids.size() == 4) begin
      chk("rr_order0", 8'(rr_ids[0]), 8'd7);
      chk("rr_order1", 8'(rr_ids[1]), 8'd2);
      chk("rr_order2", 8'(rr_ids[2]), 8'd0);
      chk("rr_order3", 8'(rr_ids[3]), 8'd7);
    end

    // back to idle
    step(8'h00, 1'b1, 1'b1);
    step(8'h00, 1'b0, 1'b1);

    // timeout: four grant cycles, preempt gap, regrant
    for (int i = 1; i <= 10; i++) begin
      step(8'h10, 1'b0, 1'b1);
      if (i == 4) chk("to_last_grant", gnt_rr, 8'h10);
      if (i == 5) begin
        chk("to_gap", gnt_rr, 8'h00);
        chk("to_preempt", {7'd0, pre_rr}, 8'h01);
      end
      if (i == 6) chk("to_regrant", gnt_rr, 8'h10);
    end

    // withdrawal mid-grant
    step(8'h00, 1'b0, 1'b1);
    step(8'h10, 1'b0, 1'b1);
    step(8'h10, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b1);
    chk("wd_gnt", gnt_rr, 8'h00);
    chk("wd_preempt", {7'd0, pre_rr}, 8'h00);

    // done coincides with timeout
    step(8'h00, 1'b0, 1'b1);
    step(8'h10, 1'b0, 1'b1);
    step(8'h10, 1'b0, 1'b1);
    step(8'h10, 1'b0, 1'b1);
    step(8'h10, 1'b0, 1'b1);
    step(8'h10, 1'b1, 1'b1);
    chk("coin_valid", {7'd0, val_rr}, 8'h00);
    chk("coin_preempt", {7'd0, pre_rr}, 8'h00);

    // reset mid-grant: id 7 owns, reset for one cycle, history lost
    step(8'h00, 1'b0, 1'b1);
    step(8'h80, 1'b0, 1'b1);
    step(8'h81, 1'b0, 1'b1);
    step(8'h81, 1'b0, 1'b0);
    chk("rst_mid_gnt", gnt_rr, 8'h00);
    chk("rst_mid_valid", {7'd0, val_rr}, 8'h00);
    step(8'h81, 1'b0, 1'b1);
    chk("rst_regrant", gnt_rr, 8'h80);

    // randomized traffic with sticky requests so timeouts occur
    rq = 8'h00;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) rq = 8'($urandom);
      step(rq, ($urandom_range(0, 4) == 0), ($urandom_range(0, 79) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/req_arbiter8.md
# req_arbiter8

Eight-requester arbiter that shares one downstream resource among up to eight clients. Each cycle it resolves contending requests through a masked 8-to-3 priority encode, registers a one-hot grant plus encoded ID, and holds the grant until the owner signals completion or a hold timeout expires. It sits between the requesting clients and the shared datapath, whose select input is driven by `gnt_id`.

## Interface
- `RR_EN`, default 1: 1 selects round-robin priority; 0 selects fixed priority (highest index wins).
- `MAX_HOLD`, default 16: maximum number of GRANT cycles before a forced release. 0 disables the timeout. Legal range is 0..255.
- `clk` in, 1 bit: single clock. All logic is on the rising edge.
- `rst_n` in, 1 bit: reset, synchronous and active-low.
- `req` in, 8 bits: request per client, level-sensitive.
- `done` in, 1 bit: current owner finished. Sampled only in GRANT.
- `gnt` out, 8 bits: one-hot grant, registered.
- `gnt_id` out, 3 bits: binary index of the granted client. Valid only when `gnt_valid` is 1.
- `gnt_valid` out, 1 bit: a grant is active.
- `preempt` out, 1 bit: one-cycle pulse on a timeout release.

## Operation
- **States**
  - IDLE: no grant.
  - GRANT: a client owns the resource.
- **Arbitration** is evaluated only in IDLE.
  - `masked = req & ((1 << last_id) - 1)`, i.e. request bits whose index is below `last_id`.
  - If `RR_EN` is 1 and `masked` is nonzero, the winner is the highest set index of `masked`.
  - Otherwise the winner is the highest set index of `req`.
  - With `RR_EN` = 0 the mask is forced to zero, giving pure highest-index-wins.
- **IDLE → GRANT** when `req` is nonzero.
  - Register `gnt` as the one-hot of the winner, `gnt_id` as the winner, and `gnt_valid` as 1.
  - Load `last_id` with the winner.
  - Clear `hold_cnt`.
- **GRANT → IDLE** when any one of the following holds:
  - `done` is 1;
  - `req[gnt_id]` is 0 (owner withdrew);
  - `MAX_HOLD` is nonzero and `hold_cnt` equals `MAX_HOLD - 1` (timeout).
- **Timeout-only release:** if the timeout is the only cause, assert `preempt` for exactly the first IDLE cycle. If `done` coincides with the timeout, treat it as a normal release and keep `preempt` at 0.
- **In GRANT,** `hold_cnt` increments by 1 per cycle. It is 8 bits wide and saturates at 255, so it never wraps.
- **Mandatory dead cycle:** every release passes through at least one IDLE cycle with `gnt` = 0. There is no back-to-back grant transfer.
- **Requests during GRANT** are ignored for arbitration. They are re-evaluated in the next IDLE cycle.
- **Reset values:** state IDLE; `gnt` 0x00; `gnt_id` 0; `gnt_valid` 0; `preempt` 0; `last_id` 0; `hold_cnt` 0.
- **Reset mid-grant:** the synchronous reset takes precedence over every transition. The next cycle has all outputs at their reset values and round-robin history lost.

## Timing
- Request-to-grant latency is 1 cycle. A `req` sampled at edge N in IDLE produces `gnt` valid after edge N, visible in cycle N+1.
- Release latency is 1 cycle. `done` sampled at edge N means `gnt` = 0 in cycle N+1.
- The earliest regrant appears in cycle N+2.
- Minimum grant length is 1 cycle, with `done` asserted together with the first grant cycle.
- Timeout example with `MAX_HOLD` = 4: the grant is held for exactly 4 cycles, then `gnt` = 0 and `preempt` = 1 for one cycle.
- All outputs come straight from flops. There is no combinational path from `req` or `done` to any output.

## Structure
- **Shared package `arb_pkg`:**
  - `N_REQ` = 8;
  - `ID_W` = 3;
  - the state enum `{ARB_IDLE, ARB_GRANT}`;
  - the `HOLD_W` = 8 constant.
- **Sub-module `pri_enc8`:** a combinational 8-to-3 highest-index-wins encoder with `any` flag output (when no bit is set, output is 0 and `any` = 0). Instantiate it twice, once on `masked` and once on `req`, and select between the two with a mux.

## Test plan
- **Reset:** hold `rst_n` = 0 for 2 cycles with `req` = 0xFF. Required: `gnt` = 0x00, `gnt_valid` = 0, `preempt` = 0.
- **Round-robin fairness** (`RR_EN` = 1): hold `req` = 0x85 and pulse `done` in each grant. Required: grant order is id 7, 2, 0, 7, with one 0x00 gap cycle between each grant.
- **Fixed priority** (`RR_EN` = 0): hold `req` = 0xFF and pulse `done` in each grant. Required: every grant is id 7 and `gnt` = 0x80.
- **Timeout** (`MAX_HOLD` = 4): hold `req` = 0x10 and never assert `done`. Required: `gnt` = 0x10 for 4 cycles, then 1 cycle of `gnt` = 0 with `preempt` = 1, then regrant of id 4.
- **Withdrawal and coincidence:**
  - The owner drops `req` mid-grant. Required: `gnt` = 0 on the next cycle and `preempt` = 0.
  - `done` coincides with the timeout. Required: `preempt` = 0.
- **Reset mid-grant:** with id 7 granted and `req` = 0x81, assert `rst_n` = 0 for 1 cycle. Required: all outputs are 0 the next cycle. After release, the next grant is id 7, because `last_id` was cleared and the mask is empty.
